ps2_rx_frame: RTL and testbench

- Receives PS/2 device-to-host frames and delivers one byte per valid frame. Sits directly downstream of the two debounce instances on ps2_clk and ps2_data.
- Inputs are already synchronous, glitch-free levels in the clk domain.
- Detects ps2_clk falling edges and shifts in start, 8 data bits (LSB first), odd parity and stop.
- Reports either a one-cycle valid byte or a one-cycle error with a cause code; a watchdog aborts stalled frames.

---
 rtl/ps2_rx_frame.sv | 128 ++++++++++++
 tb/tb_ps2_rx_frame.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx_frame
// Description : PS/2 device-to-host frame receiver. Samples ps2_data on
//               ps2_clk falling edges, assembles start/8 data/parity/stop,
//               and reports one byte per good frame or a coded error.
//               A watchdog aborts frames that stall between clock edges.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx_frame #(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int TCW            = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam logic [TCW-1:0] C_WD_LIMIT = TCW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] C_ERR_PARITY  = 2'b01;
  localparam logic [1:0] C_ERR_FRAMING = 2'b10;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'b11;

  state_t         r_state;
  logic           r_ps2_clk_q;
  logic [2:0]     r_bitcnt;
  logic [7:0]     r_shr;
  logic           r_par;
  logic [TCW-1:0] r_wd;
  logic           w_fall;

  // One-cycle strobe on each ps2_clk high-to-low transition.
  assign w_fall = r_ps2_clk_q & ~ps2_clk;

  // Frame FSM, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ps2_clk_q <= 1'b1;
      r_bitcnt    <= 3'd0;
      r_shr       <= 8'd0;
      r_par       <= 1'b0;
      r_wd        <= '0;
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;
      err_code    <= 2'b00;
      busy        <= 1'b0;
    end else begin
      r_ps2_clk_q <= ps2_clk;
      rx_valid    <= 1'b0;
      rx_err      <= 1'b0;

      if (w_fall) begin
        // A falling edge always restarts the watchdog and wins over timeout.
        r_wd <= '0;
        case (r_state)
          S_IDLE: begin
            if (!ps2_data) begin
              r_state  <= S_DATA;
              r_bitcnt <= 3'd0;
              busy     <= 1'b1;
            end
          end
          S_DATA: begin
            r_shr    <= {ps2_data, r_shr[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) begin
              r_state <= S_PARITY;
            end
          end
          S_PARITY: begin
            r_par   <= ps2_data;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            // Framing is checked before parity so a bad stop bit dominates.
            if (ps2_data && (^{r_shr, r_par})) begin
              rx_data  <= r_shr;
              rx_valid <= 1'b1;
            end else if (!ps2_data) begin
              rx_err   <= 1'b1;
              err_code <= C_ERR_FRAMING;
            end else begin
              rx_err   <= 1'b1;
              err_code <= C_ERR_PARITY;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end else if (r_state == S_IDLE) begin
        r_wd <= '0;
      end else if (r_wd == C_WD_LIMIT) begin
        // Stalled frame: drop partial data and report a timeout.
        r_state  <= S_IDLE;
        busy     <= 1'b0;
        r_wd     <= '0;
        r_bitcnt <= 3'd0;
        r_shr    <= 8'd0;
        rx_err   <= 1'b1;
        err_code <= C_ERR_TIMEOUT;
      end else begin
        r_wd <= r_wd + TCW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_rx_frame.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_rx_frame
// Description : Scoreboard bench for ps2_rx_frame. Stimulus pushes expected
//               pulses into a queue; a monitor pops and compares each pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_rx_frame;

  localparam int TO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [1:0] err_code;
  logic       busy;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_err;
    logic [1:0] code;
    logic [7:0] data;
    bit         timed;
    int         t;
  } exp_t;

  exp_t sb[$];
  int   n_total  = 0;
  int   n_passed = 0;
  int   last_fall_cyc = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_total++;
    if (ok) n_passed++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic push_exp(input bit is_err, input logic [1:0] code, input logic [7:0] data,
                          input bit timed, input int t);
    exp_t e;
    e.is_err = is_err; e.code = code; e.data = data; e.timed = timed; e.t = t;
    sb.push_back(e);
  endtask

  // One PS/2 bit: data set while clock high, then a 40-cycle clock period.
  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    @(negedge clk);
    last_fall_cyc = cyc;
    repeat (19) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    check(busy == 1'b1, "busy_in_frame", busy, 1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    ps2_data = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check(rx_data == 8'h00, {tag, "_rx_data"}, rx_data, 0);
    check(rx_valid == 1'b0, {tag, "_rx_valid"}, rx_valid, 0);
    check(rx_err == 1'b0, {tag, "_rx_err"}, rx_err, 0);
    check(err_code == 2'b00, {tag, "_err_code"}, err_code, 0);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rx_valid && rx_err) check(1'b0 == (rx_valid && rx_err), "valid_and_err", 1, 0);
      if (rx_valid || rx_err) begin
        check(sb.size() != 0, "unexpected_pulse", {rx_err, rx_valid}, 0);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check(rx_err == e.is_err, "pulse_kind_err", rx_err, e.is_err);
          check(rx_valid == !e.is_err, "pulse_kind_valid", rx_valid, !e.is_err);
          if (e.is_err) check(err_code == e.code, "err_code", err_code, e.code);
          check(rx_data == e.data, "rx_data", rx_data, e.data);
          if (e.timed) check(cyc == e.t, "timeout_cycle", cyc, e.t);
        end
        @(negedge clk);
        check(!rx_valid && !rx_err, "pulse_width", {rx_err, rx_valid}, 0);
      end
    end
  end

  // Global bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $display("%0d/%0d checks passed", n_passed, n_total + 1);
    $fatal(1);
  end

  initial begin
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Good frame 0x1C
    push_exp(1'b0, 2'b00, 8'h1C, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    check(busy == 1'b0, "busy_after_1c", busy, 0);
    repeat (80) @(negedge clk);

    // Back-to-back 0xF0 then 0x1C
    push_exp(1'b0, 2'b00, 8'hF0, 1'b0, 0);
    send_frame(8'hF0, 1'b1, 1'b1);
    repeat (80) @(negedge clk);
    push_exp(1'b0, 2'b00, 8'h1C, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    repeat (40) @(negedge clk);

    // Parity error; rx_data holds 0x1C
    push_exp(1'b1, 2'b01, 8'h1C, 1'b0, 0);
    send_frame(8'h1C, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    check(err_code == 2'b01, "err_code_holds", err_code, 1);
    check(rx_data == 8'h1C, "rx_data_holds", rx_data, 8'h1C);

    // Framing error, good parity
    push_exp(1'b1, 2'b10, 8'h1C, 1'b0, 0);
    send_frame(8'hAA, 1'b1, 1'b0);
    repeat (40) @(negedge clk);

    // Framing error with bad parity: framing wins
    push_exp(1'b1, 2'b10, 8'h1C, 1'b0, 0);
    send_frame(8'hAA, 1'b0, 1'b0);
    repeat (40) @(negedge clk);

    // Timeout: start plus 4 data bits, then clock held high
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    ps2_data = 1'b1;
    push_exp(1'b1, 2'b11, 8'h1C, 1'b1, last_fall_cyc + TO);
    repeat (60) @(negedge clk);
    check(busy == 1'b0, "busy_after_timeout", busy, 0);
    check(sb.size() == 0, "timeout_seen", sb.size(), 0);

    // Recovery frame 0xAA
    push_exp(1'b0, 2'b00, 8'hAA, 1'b0, 0);
    send_frame(8'hAA, 1'b1, 1'b1);
    repeat (40) @(negedge clk);

    // Reset after the 5th data bit
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("midreset");
    repeat (40) @(negedge clk);
    check(busy == 1'b0, "busy_after_midreset", busy, 0);
    push_exp(1'b0, 2'b00, 8'h55, 1'b0, 0);
    send_frame(8'h55, 1'b1, 1'b1);
    repeat (40) @(negedge clk);

    // ps2_clk held low through and after reset
    ps2_data = 1'b1;
    ps2_clk  = 1'b0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check(busy == 1'b0, "busy_clk_low_reset", busy, 0);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    check(busy == 1'b0, "busy_clk_release", busy, 0);
    check(rx_data == 8'h00, "rx_data_clk_low_reset", rx_data, 0);

    // Fall with data high in IDLE is ignored
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    check(busy == 1'b0, "busy_idle_fall_high", busy, 0);
    ps2_clk = 1'b1;
    repeat (100) @(negedge clk);
    check(busy == 1'b0, "busy_idle_end", busy, 0);

    check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
`default_nettype wire
